// File: rtl/tone_cordic_scheduler.sv
// tone_cordic_scheduler: time-shares one CORDIC core between two tone channels and averages their sines
module tone_cordic_scheduler #(
    parameter int PHASE_INC_A = 200,
    parameter int PHASE_INC_B = 3000,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sample_tick,
    output logic        m_axis_phase_tvalid,
    output logic [15:0] m_axis_phase_tdata,
    input  logic        s_axis_dout_tvalid,
    input  logic [31:0] s_axis_dout_tdata,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        busy,
    output logic        err_overrun,
    output logic        err_timeout
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic signed [16:0] PI_POS = 17'sh06488;
    localparam logic signed [16:0] TWO_PI = 17'sd51472;
    localparam logic [15:0] INC_A = 16'(PHASE_INC_A);
    localparam logic [15:0] INC_B = 16'(PHASE_INC_B);

    typedef enum logic [2:0] {IDLE, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, SUM} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   phase_a, phase_b, sin_a, sin_b;
    logic          unused_cos;

    function automatic logic [15:0] wrap(input logic [15:0] acc, input logic [15:0] inc);
        logic signed [16:0] s;
        s = $signed({acc[15], acc}) + $signed({inc[15], inc});
        return (s > PI_POS) ? 16'(s - TWO_PI) : 16'(s);
    endfunction

    assign busy = state != IDLE;
    assign unused_cos = ^s_axis_dout_tdata[15:0];

    // round sequencer: issue A, wait, issue B, wait, average; outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            phase_a <= '0;
            phase_b <= '0;
            sin_a <= '0;
            sin_b <= '0;
            m_axis_phase_tvalid <= 1'b0;
            m_axis_phase_tdata <= '0;
            sample_out <= '0;
            sample_valid <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            m_axis_phase_tvalid <= 1'b0;
            sample_valid <= 1'b0;
            if (en && sample_tick && state != IDLE)
                err_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (en && sample_tick) begin
                        state <= ISSUE_A;
                        m_axis_phase_tvalid <= 1'b1;
                        m_axis_phase_tdata <= phase_a;
                    end
                end
                ISSUE_A: begin
                    phase_a <= wrap(phase_a, INC_A);
                    cnt <= '0;
                    state <= WAIT_A;
                end
                WAIT_A: begin
                    if (s_axis_dout_tvalid) begin
                        sin_a <= s_axis_dout_tdata[31:16];
                        state <= ISSUE_B;
                        m_axis_phase_tvalid <= 1'b1;
                        m_axis_phase_tdata <= phase_b;
                    end else if (cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ISSUE_B: begin
                    phase_b <= wrap(phase_b, INC_B);
                    cnt <= '0;
                    state <= WAIT_B;
                end
                WAIT_B: begin
                    if (s_axis_dout_tvalid) begin
                        sin_b <= s_axis_dout_tdata[31:16];
                        state <= SUM;
                    end else if (cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SUM: begin
                    sample_out <= 16'(({sin_a[15], sin_a} + {sin_b[15], sin_b}) >> 1);
                    sample_valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_cordic_scheduler.sv
// tb_tone_cordic_scheduler: table-driven and randomized checks against a mock CORDIC with latency 3
module tb_tone_cordic_scheduler;
    localparam int L = 3;
    localparam int INC_A = 200;
    localparam int INC_B = 3000;

    logic        clk = 1'b0;
    logic        rst, en, sample_tick;
    logic        m_axis_phase_tvalid;
    logic [15:0] m_axis_phase_tdata;
    logic        s_axis_dout_tvalid;
    logic [31:0] s_axis_dout_tdata;
    logic [15:0] sample_out;
    logic        sample_valid, busy, err_overrun, err_timeout;

    tone_cordic_scheduler #(.PHASE_INC_A(INC_A), .PHASE_INC_B(INC_B), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
        .m_axis_phase_tvalid(m_axis_phase_tvalid), .m_axis_phase_tdata(m_axis_phase_tdata),
        .s_axis_dout_tvalid(s_axis_dout_tvalid), .s_axis_dout_tdata(s_axis_dout_tdata),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0, errors = 0;
    int          na, nb;
    int          n_iss, n_sv, sv_cyc, to_cyc, busy_drop;
    logic        busy_rst;
    logic [15:0] iss_w[2];
    logic [15:0] sv_val;

    // phase after k advances: k*inc reduced into (-pi, +pi] of the 1.2.13 grid
    function automatic logic [15:0] model_phase(input int inc, input int k);
        longint v;
        v = (longint'(k) * inc + 25735) % 51472 - 25735;
        return 16'(v);
    endfunction

    // floor of the mean of two signed words
    function automatic logic [15:0] model_avg(input logic [15:0] a, input logic [15:0] b);
        int s, q;
        s = int'($signed(a)) + int'($signed(b));
        q = (s >= 0) ? s / 2 : -((1 - s) / 2);
        return 16'(q);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // one tick plus ncyc observed cycles; the task also plays the CORDIC
    // mode 0 echoes the phase as sine, mode 1 answers fa then fb, mode 2 never answers
    task automatic round(input int mode, input logic [15:0] fa, input logic [15:0] fb,
                         input int xt, input int ra, input int eoff, input int ncyc);
        int          resp_at;
        logic [15:0] resp_w;
        n_iss = 0; n_sv = 0; sv_cyc = -1; to_cyc = -1; busy_drop = -1; busy_rst = 1'bx;
        resp_at = -1; resp_w = '0; sv_val = 'x;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= ncyc; i++) begin
            s_axis_dout_tvalid = 1'b0;
            sample_tick = 1'b0;
            rst = 1'b0;
            if (m_axis_phase_tvalid) begin
                if (n_iss < 2) iss_w[n_iss] = m_axis_phase_tdata;
                if (mode != 2) begin
                    resp_at = i + L;
                    resp_w = (mode == 0) ? m_axis_phase_tdata : (n_iss == 0 ? fa : fb);
                end
                n_iss++;
            end
            if (sample_valid) begin
                n_sv++;
                sv_cyc = i;
                sv_val = sample_out;
            end
            if (err_timeout && to_cyc < 0) to_cyc = i;
            if (!busy && busy_drop < 0) busy_drop = i;
            if (i == ra + 1) busy_rst = busy;
            if (i == resp_at) begin
                s_axis_dout_tvalid = 1'b1;
                s_axis_dout_tdata = {resp_w, 16'h0000};
            end
            if (i == xt) sample_tick = 1'b1;
            if (i == ra) rst = 1'b1;
            if (i == eoff) en = 1'b0;
            @(negedge clk);
        end
        s_axis_dout_tvalid = 1'b0;
        sample_tick = 1'b0;
        rst = 1'b0;
        en = 1'b1;
    endtask

    task automatic expect_round(input int mode, input logic [15:0] fa, input logic [15:0] fb,
                                input logic [15:0] y);
        logic [15:0] ea, eb, ey;
        ea = model_phase(INC_A, na);
        eb = model_phase(INC_B, nb);
        ey = (mode == 0) ? model_avg(ea, eb) : y;
        round(mode, fa, fb, -1, -1, -1, 14);
        chk("issues", n_iss, 2);
        chk("phase_a", iss_w[0], ea);
        chk("phase_b", iss_w[1], eb);
        chk("sample_count", n_sv, 1);
        chk("latency", sv_cyc, 2 * L + 4);
        chk("sample_out", sv_val, ey);
        na++;
        nb++;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        na = 0;
        nb = 0;
    endtask

    initial begin
        vecs[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[1] = '{16'hFFFD, 16'h0000, 16'hFFFE};
        vecs[2] = '{16'h8000, 16'h8000, 16'h8000};
        vecs[3] = '{16'h0001, 16'h0000, 16'h0000};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[5] = '{16'h7FFF, 16'h8000, 16'hFFFF};
        rst = 1'b1; en = 1'b0; sample_tick = 1'b0;
        s_axis_dout_tvalid = 1'b0; s_axis_dout_tdata = '0;
        na = 0; nb = 0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", m_axis_phase_tvalid, 0);
        chk("rst_tdata", m_axis_phase_tdata, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_overrun, err_timeout}, 0);
        rst = 1'b0;
        // ticks with en low are ignored silently
        en = 1'b0;
        round(0, 0, 0, -1, -1, -1, 14);
        chk("en0_issues", n_iss, 0);
        chk("en0_samples", n_sv, 0);
        chk("en0_errs", {err_overrun, err_timeout}, 0);
        en = 1'b1;
        // no CORDIC answer: abort after 64 WAIT_A cycles
        round(2, 0, 0, -1, -1, -1, 80);
        chk("to_issues", n_iss, 1);
        chk("to_phase_a", iss_w[0], 0);
        chk("to_samples", n_sv, 0);
        chk("to_err_cycle", to_cyc, 66);
        chk("to_busy_drop", busy_drop, 66);
        na = 1;
        expect_round(0, 0, 0, 0);
        chk("to_next_a", iss_w[0], 16'd200);
        chk("to_sticky", err_timeout, 1);
        // arithmetic table
        for (int i = 0; i < 6; i++) expect_round(1, vecs[i].a, vecs[i].b, vecs[i].y);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            expect_round(1, a, b, model_avg(a, b));
        end
        // en dropped mid-round still completes
        round(0, 0, 0, -1, -1, 3, 14);
        chk("enoff_samples", n_sv, 1);
        chk("enoff_a", iss_w[0], model_phase(INC_A, na));
        na++; nb++;
        // overrun in WAIT_A
        reset_dut();
        round(0, 0, 0, 2, -1, -1, 14);
        chk("ovr_flag", err_overrun, 1);
        chk("ovr_samples", n_sv, 1);
        chk("ovr_issues", n_iss, 2);
        na = 1; nb = 1;
        expect_round(0, 0, 0, 0);
        chk("ovr_next_b", iss_w[1], 16'd3000);
        // tick during SUM counts as busy
        reset_dut();
        chk("rst_clears_ovr", err_overrun, 0);
        round(0, 0, 0, 9, -1, -1, 14);
        chk("sum_ovr_flag", err_overrun, 1);
        chk("sum_ovr_samples", n_sv, 1);
        na = 1; nb = 1;
        // reset in WAIT_B
        round(0, 0, 0, -1, 6, -1, 14);
        chk("rstmid_busy", busy_rst, 0);
        chk("rstmid_samples", n_sv, 0);
        chk("rstmid_errs", {err_overrun, err_timeout}, 0);
        na = 0; nb = 0;
        expect_round(0, 0, 0, 0);
        chk("rstmid_restart", {iss_w[0], iss_w[1]}, 0);
        // long run through both wrap points
        reset_dut();
        for (int k = 1; k <= 130; k++) begin
            expect_round(0, 0, 0, 0);
            if (k == 9) chk("wrap_b_24000", iss_w[1], 16'h5DC0);
            if (k == 10) chk("wrap_b_neg", iss_w[1], 16'hA068);
            if (k == 129) chk("wrap_a_25600", iss_w[0], 16'h6400);
            if (k == 130) chk("wrap_a_neg", iss_w[0], 16'h9BB8);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tone_cordic_scheduler.md
Name: tone_cordic_scheduler

Overview:
- Time-shares one CORDIC sin/cos core between two tone channels (A = low tone, B = high/noise tone).
- Generates the ±pi-wrapped phase words and issues them to the core over AXI-stream.
- Collects the sine results and emits one combined sample, (sinA + sinB)/2, per sample tick to the FIR lowpass input.
- Replaces the two-core, free-running phase generation in the FIR test setup with a single sequenced core.

Parameters:
- PHASE_INC_A, 200, channel A phase increment per sample (1.2.13 radians)
- PHASE_INC_B, 3000, channel B phase increment per sample (1.2.13 radians)
- TIMEOUT, 64, max cycles to wait for CORDIC output before abort

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  enable; sample ticks are accepted only while high
- sample_tick  in  1  one-cycle strobe requesting one combined sample
- m_axis_phase_tvalid  out  1  phase word valid to CORDIC (no tready; core always accepts)
- m_axis_phase_tdata  out  16  signed phase, 1.2.13
- s_axis_dout_tvalid  in  1  CORDIC result valid
- s_axis_dout_tdata  in  32  CORDIC result, {sin[31:16], cos[15:0]}, signed 1.1.14
- sample_out  out  16  signed combined sample
- sample_valid  out  1  one-cycle strobe; sample_out updated on this cycle
- busy  out  1  high whenever state != IDLE
- err_overrun  out  1  sticky: tick arrived while busy
- err_timeout  out  1  sticky: CORDIC result not returned within TIMEOUT cycles

Behaviour:
- Constants: PI_POS = 16'h6488, PI_NEG = 16'h9B78.
- Reset values: all outputs 0; phase_a = phase_b = 0; state IDLE; timeout counter 0. err flags clear only on rst.
- Wrap rule, per channel, computed in 17-bit signed:
  - s = acc + inc.
  - If s <= PI_POS: acc <= s.
  - Else: acc <= PI_NEG + (s - PI_POS), i.e. s - 2pi.
  - Both channels use inclusive <=.
- FSM states and transitions:
  - IDLE:
    - If en && sample_tick: go to ISSUE_A.
    - Otherwise stay. Ticks with en low are ignored, with no error.
  - ISSUE_A:
    - m_axis_phase_tvalid = 1, tdata = phase_a, for exactly this cycle.
    - phase_a advances by the wrap rule.
    - Clear the timeout counter; go to WAIT_A.
  - WAIT_A:
    - On s_axis_dout_tvalid: capture sin_a = tdata[31:16]; go to ISSUE_B.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without tvalid: set err_timeout and go to IDLE; no sample_valid.
  - ISSUE_B / WAIT_B: identical to ISSUE_A / WAIT_A with phase_b and sin_b. A valid result in WAIT_B goes to SUM.
  - SUM:
    - sample_out <= (17-bit sin_a + sin_b) >>> 1, arithmetic shift (rounds toward -inf).
    - sample_valid = 1 next cycle (registered, one cycle); go to IDLE.
- Only one request is ever outstanding. s_axis_dout_tvalid in IDLE, ISSUE_*, or SUM is ignored (stray result dropped).
- Latency: with CORDIC latency L cycles (tvalid L cycles after phase tvalid), sample_valid asserts 2L+4 cycles after the tick cycle.
- Tick while busy:
  - The tick is dropped and err_overrun is set.
  - The round in progress is unaffected.
  - A tick in the same cycle the FSM returns from SUM to IDLE counts as busy.
- en deasserted mid-round: the round completes normally. Only new ticks are gated.
- rst mid-round:
  - Immediate return to IDLE and all reset values; any in-flight CORDIC result is ignored.
  - The phase sequence restarts from 0.
- The phase-word sequence per channel is independent of timeouts. A channel whose phase was issued has already advanced, even if the round aborts.

Test Plan:
- Mock CORDIC returning {phase, 16'h0000} with L=3; tick every 20 cycles → phase A words 0, 200, 400, 600…; B words 0, 3000, 6000…; sample_valid 10 cycles after each tick.
- Wrap: start from reset; on tick 9, B issues 24000, then acc becomes 27000 (>PI_POS) → 27000 − 51472 = −24472 (16'hA068); A reaches exactly 25600 then 25800 → −25672.
- Arithmetic: mock sin_a = 16'h7FFF, sin_b = 16'h7FFF → sample_out 16'h7FFF; sin_a = −3, sin_b = 0 → sample_out −2 (16'hFFFE); sin_a = 16'h8000, sin_b = 16'h8000 → 16'h8000.
- Overrun: second tick 2 cycles after the first → err_overrun = 1, exactly one sample_valid, phases advance once.
- Timeout: mock never asserts dout_tvalid → err_timeout = 1 after 64 WAIT_A cycles, busy drops, no sample_valid; next tick issues phase_a = 200.
- Reset/enable: rst asserted in WAIT_B → busy = 0 next cycle, no sample_valid, next tick issues phase 0 on both channels; tick with en = 0 → no phase tvalid, no error.
